// File: rtl/tanh_lut_pkg.sv
// Shared constants, tanh sample table and stage-1 record for the tanh LUT fetch stage.
// The table holds round(16*tanh(k)) for k = 0..8 in Q3.4.
package tanh_lut_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int FRAC_W_DEF = 4;
    localparam int IDX_W      = 3;
    localparam int LUT_DEPTH  = 9;

    localparam logic [DATA_W_DEF-1:0] TANH_TABLE [LUT_DEPTH] = '{
        8'd0, 8'd12, 8'd15, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16
    };

    typedef struct packed {
        logic                  neg;
        logic [IDX_W-1:0]      idx;
        logic [FRAC_W_DEF-1:0] frac;
    } s1_rec_t;

    // The most negative input has no positive twin, so its magnitude clips to full scale.
    function automatic s1_rec_t decode_x(input logic [DATA_W_DEF-1:0] xv);
        logic [DATA_W_DEF-2:0] mag;
        s1_rec_t               rec;
        if (xv == {1'b1, {(DATA_W_DEF-1){1'b0}}})
            mag = {(DATA_W_DEF-1){1'b1}};
        else if (xv[DATA_W_DEF-1])
            mag = (DATA_W_DEF-1)'(-xv);
        else
            mag = xv[DATA_W_DEF-2:0];
        rec.neg  = xv[DATA_W_DEF-1];
        rec.idx  = mag[FRAC_W_DEF+IDX_W-1:FRAC_W_DEF];
        rec.frac = mag[FRAC_W_DEF-1:0];
        return rec;
    endfunction

endpackage

// File: rtl/tanh_lut_rom.sv
// Combinational dual-port read of the activation table at idx and idx+1.
// Kept separate so the sigmoid variant can swap in its own table.
module tanh_lut_rom
    import tanh_lut_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [IDX_W-1:0]  i_idx,
    output logic [DATA_W-1:0] o_lo,
    output logic [DATA_W-1:0] o_hi
);

    logic [IDX_W:0] w_idx_lo;
    logic [IDX_W:0] w_idx_hi;

    assign w_idx_lo = {1'b0, i_idx};
    assign w_idx_hi = w_idx_lo + {{IDX_W{1'b0}}, 1'b1};

    assign o_lo = DATA_W'(TANH_TABLE[w_idx_lo]);
    assign o_hi = DATA_W'(TANH_TABLE[w_idx_hi]);

endmodule

// File: rtl/tanh_lut_fetch.sv
// Two-stage decode/fetch feeding the tanh interpolator with base, next, change and fraction.
// Define TANH_LUT_SKID_EN to register ready_in behind a 1-entry input skid buffer.
module tanh_lut_fetch
    import tanh_lut_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] base,
    output logic [DATA_W-1:0] next_data,
    output logic [DATA_W-1:0] change,
    output logic [DATA_W-1:0] remaining,
    output logic              valid_out,
    input  logic              ready_out
);

    s1_rec_t           r_s1;
    logic              r_s1_valid;
    logic              r_valid_out;
    logic [DATA_W-1:0] r_base;
    logic [DATA_W-1:0] r_next;
    logic [DATA_W-1:0] r_change;
    logic [DATA_W-1:0] r_remaining;

    logic              w_adv;
    logic              w_s1_en;
    logic [DATA_W-1:0] w_t_lo;
    logic [DATA_W-1:0] w_t_hi;
    logic [DATA_W-1:0] w_base;
    logic [DATA_W-1:0] w_next;

    assign w_adv   = !r_valid_out || ready_out;
    assign w_s1_en = !r_s1_valid || w_adv;

`ifdef TANH_LUT_SKID_EN
    logic              r_skid_full;
    logic              r_ready_in;
    logic [DATA_W-1:0] r_skid_x;
    logic              w_in_acc;

    assign ready_in = r_ready_in;
    assign w_in_acc = valid_in && r_ready_in;

    // A held skid entry always drains into stage 1 ahead of new input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1        <= '0;
            r_s1_valid  <= 1'b0;
            r_skid_x    <= '0;
            r_skid_full <= 1'b0;
            r_ready_in  <= 1'b0;
        end else if (w_s1_en) begin
            if (r_skid_full) begin
                r_s1        <= decode_x(r_skid_x);
                r_s1_valid  <= 1'b1;
                r_skid_full <= 1'b0;
            end else begin
                r_s1_valid <= w_in_acc;
                if (w_in_acc)
                    r_s1 <= decode_x(x);
            end
            r_ready_in <= 1'b1;
        end else begin
            if (w_in_acc) begin
                r_skid_x    <= x;
                r_skid_full <= 1'b1;
            end
            r_ready_in <= !(r_skid_full || w_in_acc);
        end
    end
`else
    assign ready_in = w_s1_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= valid_in;
            if (valid_in)
                r_s1 <= decode_x(x);
        end
    end
`endif

    tanh_lut_rom #(
        .DATA_W (DATA_W)
    ) u_rom (
        .i_idx (r_s1.idx),
        .o_lo  (w_t_lo),
        .o_hi  (w_t_hi)
    );

    // Odd symmetry: tanh(-x) = -tanh(x).
    assign w_base = r_s1.neg ? -w_t_lo : w_t_lo;
    assign w_next = r_s1.neg ? -w_t_hi : w_t_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_out <= 1'b0;
            r_base      <= '0;
            r_next      <= '0;
            r_change    <= '0;
            r_remaining <= '0;
        end else if (w_adv) begin
            r_valid_out <= r_s1_valid;
            if (r_s1_valid) begin
                r_base      <= w_base;
                r_next      <= w_next;
                r_change    <= w_next - w_base;
                r_remaining <= DATA_W'(r_s1.frac);
            end
        end
    end

    assign valid_out = r_valid_out;
    assign base      = r_base;
    assign next_data = r_next;
    assign change    = r_change;
    assign remaining = r_remaining;

endmodule
